// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with trap/branch redirects, optional
// 16-bit instruction steps and a small circular return-address stack.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = {XLEN{1'b0}},
  parameter int              RAS_DEPTH = 4,
  parameter bit              C_EXT     = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc,
  input  logic            is_c,
  input  logic            redir_valid,
  input  logic            redir_rel,
  input  logic [XLEN-1:0] redir_addr,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            call_push,
  input  logic            ret_pop,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = C_EXT ? {{(XLEN-1){1'b1}}, 1'b0}
                                                 : {{(XLEN-2){1'b1}}, 2'b00};

  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return (addr & ~ALIGN_MASK) == {XLEN{1'b0}};
  endfunction

  logic [XLEN-1:0] pc_r;
  logic            started_r;
  logic [XLEN-1:0] ras_r [RAS_DEPTH];
  logic [PW-1:0]   ptr_r;
  logic [CW-1:0]   cnt_r;
  logic            misalign_r;
  logic [XLEN-1:0] misalign_addr_r;

  logic            accept_s;
  logic [XLEN-1:0] step_s;
  logic [XLEN-1:0] seq_s;
  logic [XLEN-1:0] tgt_s;
  logic [PW-1:0]   top_idx_s;
  logic            pop_hit_s;
  logic [XLEN-1:0] pc_nxt_s;
  logic [PW-1:0]   ptr_nxt_s;
  logic [CW-1:0]   cnt_nxt_s;
  logic            ras_we_s;
  logic [PW-1:0]   ras_widx_s;
  logic            mis_nxt_s;
  logic [XLEN-1:0] mis_addr_nxt_s;

  assign fetch_valid   = started_r & ~stall;
  assign pc            = pc_r;
  assign misalign      = misalign_r;
  assign misalign_addr = misalign_addr_r;

  assign accept_s  = fetch_valid & fetch_ready;
  assign step_s    = (C_EXT && is_c) ? XLEN'(2) : XLEN'(4);
  assign seq_s     = pc_r + step_s;
  assign tgt_s     = redir_rel ? (pc_r + redir_addr) : redir_addr;
  // ptr_r names the next free slot, so the top sits one below it.
  assign top_idx_s = ptr_r - PW'(1);
  assign pop_hit_s = ret_pop && (cnt_r != {CW{1'b0}});

  // Next-state selection in priority order: trap, redirect, stall, accept.
  always_comb begin
    pc_nxt_s       = pc_r;
    ptr_nxt_s      = ptr_r;
    cnt_nxt_s      = cnt_r;
    ras_we_s       = 1'b0;
    ras_widx_s     = ptr_r;
    mis_nxt_s      = 1'b0;
    mis_addr_nxt_s = misalign_addr_r;
    if (trap_valid) begin
      pc_nxt_s = trap_vec & ALIGN_MASK;
    end else if (redir_valid) begin
      if (is_aligned(tgt_s)) begin
        pc_nxt_s = tgt_s;
      end else begin
        mis_nxt_s      = 1'b1;
        mis_addr_nxt_s = tgt_s;
      end
    end else if (stall) begin
      pc_nxt_s = pc_r;
    end else if (accept_s) begin
      pc_nxt_s = pop_hit_s ? ras_r[top_idx_s] : seq_s;
      // A call+return pair on a live stack swaps the top in place.
      if (call_push && pop_hit_s) begin
        ras_we_s   = 1'b1;
        ras_widx_s = top_idx_s;
      end else if (call_push) begin
        ras_we_s  = 1'b1;
        ptr_nxt_s = ptr_r + PW'(1);
        cnt_nxt_s = (cnt_r == CW'(RAS_DEPTH)) ? cnt_r : cnt_r + CW'(1);
      end else if (pop_hit_s) begin
        ptr_nxt_s = top_idx_s;
        cnt_nxt_s = cnt_r - CW'(1);
      end else begin
        ras_we_s = 1'b0;
      end
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // Architectural PC, stack bookkeeping and misalign reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r            <= RESET_VEC;
      started_r       <= 1'b0;
      ptr_r           <= {PW{1'b0}};
      cnt_r           <= {CW{1'b0}};
      misalign_r      <= 1'b0;
      misalign_addr_r <= {XLEN{1'b0}};
    end else begin
      pc_r            <= pc_nxt_s;
      started_r       <= 1'b1;
      ptr_r           <= ptr_nxt_s;
      cnt_r           <= cnt_nxt_s;
      misalign_r      <= mis_nxt_s;
      misalign_addr_r <= mis_addr_nxt_s;
    end
  end

  // Return-address storage; the fall-through address is always seq_s.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_r[i] <= {XLEN{1'b0}};
      end
    end else if (ras_we_s) begin
      ras_r[ras_widx_s] <= seq_s;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: the driver queues hand-computed per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_pc_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, fetch_ready, is_c, redir_valid, redir_rel;
  logic        trap_valid, call_push, ret_pop;
  logic [31:0] redir_addr, trap_vec;
  logic        fetch_valid, misalign;
  logic [31:0] pc, misalign_addr;

  logic        is_c_c, trap_valid_c;
  logic [31:0] trap_vec_c;
  logic        fv_c, mis_c;
  logic [31:0] pc_c, maddr_c;

  pc_gen u_dut (
    .clk(clk), .rst(rst), .stall(stall), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .pc(pc), .is_c(is_c),
    .redir_valid(redir_valid), .redir_rel(redir_rel), .redir_addr(redir_addr),
    .trap_valid(trap_valid), .trap_vec(trap_vec),
    .call_push(call_push), .ret_pop(ret_pop),
    .misalign(misalign), .misalign_addr(misalign_addr)
  );

  pc_gen #(.C_EXT(1'b1)) u_dut_c (
    .clk(clk), .rst(rst), .stall(1'b0), .fetch_valid(fv_c),
    .fetch_ready(1'b1), .pc(pc_c), .is_c(is_c_c),
    .redir_valid(1'b0), .redir_rel(1'b0), .redir_addr(32'h0000_0000),
    .trap_valid(trap_valid_c), .trap_vec(trap_vec_c),
    .call_push(1'b0), .ret_pop(1'b0),
    .misalign(mis_c), .misalign_addr(maddr_c)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        fv;
    logic        mis;
    logic [31:0] maddr;
    logic        chk_c;
    logic [31:0] pc_c;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] ma;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("pc", pc, e.pc);
      check("fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
      check("misalign", {31'd0, misalign}, {31'd0, e.mis});
      check("misalign_addr", misalign_addr, e.maddr);
      if (e.chk_c) check("pc_cext", pc_c, e.pc_c);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_s(input logic [31:0] p, input logic fv, input logic m);
    q.push_back('{pc: p, fv: fv, mis: m, maddr: ma, chk_c: 1'b0, pc_c: 32'h0});
    tick();
  endtask

  task automatic exp_c(input logic [31:0] p, input logic fv, input logic m, input logic [31:0] pcc);
    q.push_back('{pc: p, fv: fv, mis: m, maddr: ma, chk_c: 1'b1, pc_c: pcc});
    tick();
  endtask

  task automatic redir(input logic v, input logic rel, input logic [31:0] a);
    redir_valid = v;
    redir_rel   = rel;
    redir_addr  = a;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; fetch_ready = 1'b0; is_c = 1'b0;
    redir(1'b0, 1'b0, 32'h0); trap_valid = 1'b0; trap_vec = 32'h0;
    call_push = 1'b0; ret_pop = 1'b0;
    is_c_c = 1'b0; trap_valid_c = 1'b0; trap_vec_c = 32'h0; ma = 32'h0;
    tick();
    // reset, start-up bubble, free run (C_EXT instance steps by 2, then 4)
    exp_c(32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0; fetch_ready = 1'b1; is_c_c = 1'b1;
    exp_c(32'h0, 1'b0, 1'b0, 32'h0);
    exp_c(32'h0, 1'b1, 1'b0, 32'h0);
    exp_c(32'h4, 1'b1, 1'b0, 32'h2);
    is_c_c = 1'b0;
    exp_c(32'h8, 1'b1, 1'b0, 32'h4);
    trap_valid_c = 1'b1; trap_vec_c = 32'h8000_0003;
    exp_c(32'hC, 1'b1, 1'b0, 32'h8);
    trap_valid_c = 1'b0; stall = 1'b1;
    exp_c(32'h10, 1'b0, 1'b0, 32'h8000_0002);
    // stall and handshake hold
    exp_s(32'h10, 1'b0, 1'b0);
    exp_s(32'h10, 1'b0, 1'b0);
    stall = 1'b0; fetch_ready = 1'b0;
    exp_s(32'h10, 1'b1, 1'b0);
    exp_s(32'h10, 1'b1, 1'b0);
    // redirects and trap priority
    fetch_ready = 1'b1; redir(1'b1, 1'b0, 32'h100);
    exp_s(32'h10, 1'b1, 1'b0);
    redir(1'b1, 1'b1, 32'hFFFF_FFF0);
    exp_s(32'h100, 1'b1, 1'b0);
    redir(1'b1, 1'b0, 32'h2000); stall = 1'b1;
    exp_s(32'hF0, 1'b0, 1'b0);
    stall = 1'b0; redir(1'b1, 1'b0, 32'h3000); trap_valid = 1'b1; trap_vec = 32'h8000_0003;
    exp_s(32'h2000, 1'b1, 1'b0);
    trap_valid = 1'b0; redir(1'b1, 1'b0, 32'h40);
    exp_s(32'h8000_0000, 1'b1, 1'b0);
    // misaligned redirects, single and back-to-back
    redir(1'b1, 1'b0, 32'h1002);
    exp_s(32'h40, 1'b1, 1'b0);
    redir(1'b0, 1'b0, 32'h0); ma = 32'h1002;
    exp_s(32'h40, 1'b1, 1'b1);
    redir(1'b1, 1'b0, 32'h2001);
    exp_s(32'h44, 1'b1, 1'b0);
    redir(1'b1, 1'b1, 32'h2); ma = 32'h2001;
    exp_s(32'h44, 1'b1, 1'b1);
    redir(1'b0, 1'b0, 32'h0); ma = 32'h46;
    exp_s(32'h44, 1'b1, 1'b1);
    redir(1'b1, 1'b0, 32'h10);
    exp_s(32'h48, 1'b1, 1'b0);
    // five calls from 0x10..0x50; the fifth overwrites the 0x14 entry
    for (int i = 1; i <= 5; i++) begin
      redir(1'b0, 1'b0, 32'h0); call_push = 1'b1;
      exp_s(32'(i * 16), 1'b1, 1'b0);
      call_push = 1'b0;
      if (i < 5) begin
        redir(1'b1, 1'b0, 32'((i + 1) * 16));
        exp_s(32'(i * 16 + 4), 1'b1, 1'b0);
      end
    end
    redir(1'b0, 1'b0, 32'h0); ret_pop = 1'b1;
    exp_s(32'h54, 1'b1, 1'b0);
    exp_s(32'h54, 1'b1, 1'b0);
    exp_s(32'h44, 1'b1, 1'b0);
    ret_pop = 1'b0; redir(1'b1, 1'b0, 32'h60);
    exp_s(32'h34, 1'b1, 1'b0);
    redir(1'b0, 1'b0, 32'h0); call_push = 1'b1; ret_pop = 1'b1;
    exp_s(32'h60, 1'b1, 1'b0);
    call_push = 1'b0;
    exp_s(32'h24, 1'b1, 1'b0);
    exp_s(32'h64, 1'b1, 1'b0);
    call_push = 1'b1;
    exp_s(32'h68, 1'b1, 1'b0);
    call_push = 1'b0; fetch_ready = 1'b0;
    exp_s(32'h6C, 1'b1, 1'b0);
    fetch_ready = 1'b1; redir(1'b1, 1'b0, 32'h200);
    exp_s(32'h6C, 1'b1, 1'b0);
    redir(1'b0, 1'b0, 32'h0);
    exp_s(32'h200, 1'b1, 1'b0);
    exp_s(32'h6C, 1'b1, 1'b0);
    ret_pop = 1'b0;
    // address wrap
    redir(1'b1, 1'b0, 32'hFFFF_FFFC);
    exp_s(32'h70, 1'b1, 1'b0);
    redir(1'b0, 1'b0, 32'h0);
    exp_s(32'hFFFF_FFFC, 1'b1, 1'b0);
    exp_s(32'h0, 1'b1, 1'b0);
    // reset wins over a stalled redirect
    rst = 1'b1; stall = 1'b1; redir(1'b1, 1'b0, 32'h500);
    exp_s(32'h4, 1'b0, 1'b0);
    rst = 1'b0; stall = 1'b0; redir(1'b0, 1'b0, 32'h0); ma = 32'h0;
    exp_s(32'h0, 1'b0, 1'b0);
    exp_s(32'h0, 1'b1, 1'b0);
    exp_s(32'h4, 1'b1, 1'b0);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage. It holds the architectural fetch PC and offers it to the instruction fetch unit over a valid/ready handshake. It also applies trap and branch redirects, with absolute or PC-relative targets, and handles an optional 16-bit instruction step. A small return-address stack (RAS) predicts return targets. Sits between the control/trap logic and the instruction memory port, in place of the fixed 32-bit counter.

## Interface
- XLEN, 32, address width.
- RESET_VEC, 0, PC value loaded on reset; must be aligned to 4.
- RAS_DEPTH, 4, RAS entries; power of two, ≥2.
- C_EXT, 0, 1 enables 2-byte steps and 2-byte target alignment.

- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- stall  in  1  hold PC and suppress fetch_valid.
- fetch_valid  out  1  pc is a valid fetch request.
- fetch_ready  in  1  fetch unit accepts pc.
- pc  out  XLEN  current fetch PC.
- is_c  in  1  accepted instruction is 16-bit; ignored when C_EXT=0.
- redir_valid  in  1  branch/jump redirect.
- redir_rel  in  1  1: target = pc + redir_addr; 0: target = redir_addr.
- redir_addr  in  XLEN  absolute target or signed offset.
- trap_valid  in  1  trap redirect.
- trap_vec  in  XLEN  trap handler address.
- call_push  in  1  accepted instruction is a call; push its fall-through address.
- ret_pop  in  1  accepted instruction is a return; predict from RAS.
- misalign  out  1  one-cycle pulse: redirect target misaligned.
- misalign_addr  out  XLEN  offending target, held until next misalign.

## Operation
- step = 2 if (C_EXT && is_c) else 4.
- accept = fetch_valid && fetch_ready.
- All arithmetic is modulo 2^XLEN; wrap from all-ones is legal and silent.
- fetch_valid = started && !stall, where started is a register cleared by rst and set on the first cycle after rst.
- Per-cycle priority: rst > trap_valid > redir_valid > stall > accept > hold.
- rst:
  - pc ← RESET_VEC.
  - RAS count ← 0, RAS pointer ← 0.
  - misalign ← 0, misalign_addr ← 0.
- trap_valid: pc ← trap_vec with low 2 bits cleared (low 1 bit if C_EXT). Overrides stall. Redirect and RAS inputs are ignored.
- redir_valid:
  - tgt = redir_rel ? pc + redir_addr : redir_addr.
  - Aligned target (tgt[1:0]==0, or tgt[0]==0 when C_EXT): pc ← tgt.
  - Misaligned target: pc holds, misalign ← 1, misalign_addr ← tgt.
  - Overrides stall. RAS is untouched.
- accept, no higher-priority event:
  - ret_pop with RAS count > 0: pc ← RAS top; pointer decrements; count decrements.
  - ret_pop with empty RAS: treated as sequential, pc ← pc + step.
  - Otherwise: pc ← pc + step.
  - call_push: pushes pc + step. Pointer increments modulo RAS_DEPTH. Count saturates at RAS_DEPTH; when full, the oldest entry is overwritten.
  - call_push && ret_pop on a non-empty RAS: pc ← old top, the top entry is replaced by pc + step, count and pointer unchanged.
  - call_push && ret_pop on an empty RAS: sequential step plus a normal push.
- call_push/ret_pop without accept (or under stall, trap or redirect) have no effect.
- stall without trap/redirect: pc and RAS hold.

## Timing
- Every state change is visible on pc, misalign and misalign_addr the cycle after the causing input. No combinational path from inputs to pc.
- fetch_valid combinationally follows stall; it is low during rst and during the first cycle after rst.
- Relative redirect uses the pc value present in the same cycle as redir_valid.
- misalign is high for exactly one cycle per misaligned redirect. Back-to-back misaligned redirects give consecutive pulses, and misalign_addr updates each time.
- Reset mid-stall or mid-redirect: rst wins; pc = RESET_VEC the next cycle.
- RAS push/pop within one accept take one cycle. The popped value is available on pc the next cycle.

## Test plan
- Reset then free-run: rst 1 cycle, fetch_ready=1 → pc 0, 0 (fetch_valid=0 that cycle), 4, 8, 12. C_EXT=1 with is_c=1 → steps of 2.
- Stall and handshake: pc=0x10, stall=1 for 3 cycles → pc stays 0x10 and fetch_valid=0. fetch_ready=0 with stall=0 → pc holds 0x10 with fetch_valid=1.
- Redirects:
  - pc=0x100, redir_rel=1, redir_addr=0xFFFFFFF0 → pc=0xF0.
  - Absolute 0x2000 together with stall=1 → pc=0x2000.
  - trap_valid with redir_valid, trap_vec=0x80000003 → pc=0x80000000.
- Misalign, C_EXT=0: pc=0x40, absolute redirect to 0x1002 → pc stays 0x40, misalign pulses once, misalign_addr=0x1002.
- RAS, RAS_DEPTH=4:
  - Push from pc 0x10, 0x20, 0x30, 0x40, 0x50; the fifth push overwrites the 0x14 entry.
  - Five pops → 0x54, 0x44, 0x34, 0x24, then sequential step.
  - Simultaneous push+pop at pc 0x60 with top 0x24 → pc=0x24, top becomes 0x64.
- Wrap: pc=0xFFFFFFFC, accept → pc=0x00000000, no misalign.
